uart_loopback_fifo: RTL
=======================

Name: uart_loopback_fifo

Overview:
- Byte buffer between the UART receive path and the UART transmit path in the loopback top level.
- Captures every received byte into a synchronous FIFO, then replays the bytes one at a time into the transmitter, waiting for each transmission to finish.
- Prevents lost echo bytes when bytes arrive back-to-back while the transmitter is busy.
- Reports occupancy and overflow so the top level can drive an error LED.

Parameters:
- PACK_SIZE, 8, width of one UART data byte in bits.
- DEPTH, 16, number of FIFO entries; must be a power of two and at least 2.
- START_TIMEOUT, 4, clock cycles to wait for tx_active to rise after a tx_byte_valid pulse before the byte is treated as sent.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  asynchronous, active-high reset.
- rx_byte_valid  input  1  single-cycle strobe: rx_byte_data is valid this cycle.
- rx_byte_data  input  PACK_SIZE  received byte.
- tx_active  input  1  high while the transmitter is shifting a frame.
- tx_byte_valid  output  1  single-cycle strobe requesting transmission of tx_byte_data.
- tx_byte_data  output  PACK_SIZE  byte to transmit; held stable until the next pop.
- fifo_count  output  $clog2(DEPTH)+1  number of stored bytes, range 0..DEPTH.
- fifo_empty  output  1  fifo_count == 0.
- fifo_full  output  1  fifo_count == DEPTH.
- overflow  output  1  single-cycle strobe: an incoming byte was dropped.

Behaviour:
- Reset (async assert, sync release): wr_ptr=rd_ptr=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0, tx_byte_valid=0, tx_byte_data=0, state=IDLE, timeout counter=0. Reset does not clear memory contents.
- Reset mid-transfer: any byte in flight is abandoned and all stored bytes are discarded. No tx_byte_valid is issued until after reset is released.
- Push:
  - Occurs on rx_byte_valid when fifo_count<DEPTH, or when a pop happens in the same cycle.
  - The data is written at wr_ptr and wr_ptr increments.
  - Pointers wrap modulo DEPTH.
- Drop:
  - rx_byte_valid while full with no same-cycle pop: the byte is discarded.
  - overflow=1 the next cycle for exactly one cycle.
  - Pointers and count are unchanged.
- Pop:
  - Occurs only in IDLE when fifo_count>0 and tx_active==0.
  - Next cycle: tx_byte_data = mem[rd_ptr] (registered) and tx_byte_valid=1 for one cycle.
  - rd_ptr increments; state moves to WAIT_START.
- Simultaneous push and pop: fifo_count is unchanged, both pointers advance, and no overflow is signalled.
- fifo_count, fifo_empty and fifo_full are registered and reflect all pushes and pops of the previous cycle.
- Latency: rx_byte_valid at cycle N into an empty FIFO with the transmitter idle gives tx_byte_valid at cycle N+2.
- FSM states:
  - IDLE: pop as above; otherwise stay.
  - WAIT_START:
    - Increment the timeout counter each cycle.
    - tx_active==1: go to WAIT_DONE and clear the counter.
    - Counter reaches START_TIMEOUT-1 with tx_active still 0: go to IDLE and clear the counter; the byte counts as sent.
  - WAIT_DONE: when tx_active==0, go to IDLE.
- Throughput: at most one byte in flight. The next pop can occur no earlier than the first cycle in IDLE.
- tx_byte_valid is never asserted outside the cycle that follows a pop.

Optional Feature:
- Macro UART_FIFO_DROP_COUNT_EN.
- Defined:
  - Adds output port drop_count, 16 bits, reset to 0.
  - Increments by 1 on each overflow strobe and saturates at 16'hFFFF.
  - Cleared only by rst.
- Not defined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Single byte, tx idle: rx_byte_valid with 8'hA5 at cycle 10 -> tx_byte_valid=1 and tx_byte_data=8'hA5 at cycle 12; fifo_count returns to 0.
- Burst while busy: hold tx_active=1 and push 8'h01..8'h05 -> fifo_count=5 and no tx_byte_valid. Then emulate 10-cycle tx frames that start 2 cycles after each tx_byte_valid -> bytes are emitted in order 01..05, with each tx_byte_valid only after tx_active falls.
- Overflow: tx_active=1 and push 17 bytes (DEPTH=16) -> fifo_full=1 and one overflow pulse on the 17th byte. The first 16 bytes replay in order; drop_count=1 when UART_FIFO_DROP_COUNT_EN is defined.
- Full plus simultaneous pop: FIFO full, tx_active falls, and rx_byte_valid with 8'h77 in the pop cycle -> no overflow, fifo_count stays 16, and 8'h77 is emitted last.
- Start timeout: tx_active tied 0 and push 8'h3C, 8'hC3 -> tx_byte_valid pulses 5 cycles apart (pop, 4 cycles WAIT_START with START_TIMEOUT=4, IDLE), each carrying the correct byte.
- Async reset mid-operation: 3 bytes queued, state WAIT_DONE, assert rst between clock edges -> outputs reach reset values immediately (fifo_count=0, fifo_empty=1, tx_byte_valid=0); after release, no tx_byte_valid until a new rx_byte_valid.

Source files
------------

// File: rtl/uart_loopback_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_loopback_fifo
// Description : Byte buffer between the UART receiver and the UART
//               transmitter of the loopback top level. Every received byte is
//               stored in a synchronous FIFO. Stored bytes are replayed one at
//               a time into the transmitter. The next byte is released only
//               after the previous frame has finished, so echo bytes that
//               arrive back-to-back while the transmitter is busy are kept.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   system clock (100 MHz)
//   rst            in   asynchronous, active-high reset
//   rx_byte_valid  in   one-cycle strobe, rx_byte_data is valid
//   rx_byte_data   in   received byte
//   tx_active      in   high while the transmitter shifts a frame
//   tx_byte_valid  out  one-cycle strobe requesting transmission
//   tx_byte_data   out  byte to transmit, held until the next pop
//   fifo_count     out  number of stored bytes, 0..DEPTH
//   fifo_empty     out  fifo_count == 0
//   fifo_full      out  fifo_count == DEPTH
//   overflow       out  one-cycle strobe, an incoming byte was dropped
//   drop_count     out  saturating count of dropped bytes
//                       (present only with UART_FIFO_DROP_COUNT_EN)
// Build option:
//   UART_FIFO_DROP_COUNT_EN - adds the drop_count port and its counter
// ============================================================================
module uart_loopback_fifo #(
    parameter int PACK_SIZE     = 8,
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_byte_valid,
    input  logic [PACK_SIZE-1:0]     rx_byte_data,
    input  logic                     tx_active,
    output logic                     tx_byte_valid,
    output logic [PACK_SIZE-1:0]     tx_byte_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic                     overflow
`ifdef UART_FIFO_DROP_COUNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam int c_tmr_w  = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    localparam logic [c_cnt_w-1:0] c_depth        = c_cnt_w'(DEPTH);
    localparam logic [c_tmr_w-1:0] c_timeout_last = c_tmr_w'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_START = 2'd1,
        S_WAIT_DONE  = 2'd2
    } state_t;

    logic [PACK_SIZE-1:0] r_mem [DEPTH];
    logic [c_addr_w-1:0]  r_wr_ptr;
    logic [c_addr_w-1:0]  r_rd_ptr;
    logic [c_tmr_w-1:0]   r_timer;
    state_t               r_state;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [c_cnt_w-1:0]   w_count_next;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // byte when a pop happens alongside it.
    assign w_pop  = (r_state == S_IDLE) && !fifo_empty && !tx_active;
    assign w_push = rx_byte_valid && (!fifo_full || w_pop);
    assign w_drop = rx_byte_valid && fifo_full && !w_pop;

    always_comb begin
        w_count_next = fifo_count;
        if (w_push && !w_pop) begin
            w_count_next = fifo_count + c_cnt_w'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = fifo_count - c_cnt_w'(1);
        end
    end

    // Storage is not reset; the pointers define which entries are live.
    // On a simultaneous push and pop into a full FIFO both pointers address
    // the same slot; the pop reads the old byte before the write lands.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_byte_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            fifo_count    <= '0;
            fifo_empty    <= 1'b1;
            fifo_full     <= 1'b0;
            overflow      <= 1'b0;
            tx_byte_valid <= 1'b0;
            tx_byte_data  <= '0;
            r_timer       <= '0;
            r_state       <= S_IDLE;
        end else begin
            fifo_count    <= w_count_next;
            fifo_empty    <= (w_count_next == '0);
            fifo_full     <= (w_count_next == c_depth);
            overflow      <= w_drop;
            tx_byte_valid <= 1'b0;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        tx_byte_data  <= r_mem[r_rd_ptr];
                        tx_byte_valid <= 1'b1;
                        r_rd_ptr      <= r_rd_ptr + c_addr_w'(1);
                        r_timer       <= '0;
                        r_state       <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    // If the transmitter never reports activity the byte is
                    // assumed sent, so a missing tx_active cannot stall us.
                    if (tx_active) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (r_timer == c_timeout_last) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_active) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_timer <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_FIFO_DROP_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (overflow && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire
